// File: rtl/mpx_pkg.sv
// rtl/mpx_pkg.sv - shared widths and limits for the FM-stereo MPX encoder
package mpx_pkg;

  localparam int W_DEF           = 16;
  localparam int B_DEF           = 32;
  localparam int PILOT_SHIFT_DEF = 3;

  // L+R needs one guard bit; the three-term accumulator needs three.
  localparam int SUMW = W_DEF + 1;
  localparam int ACCW = W_DEF + 3;

  localparam int SAT_MAX = (2 ** (W_DEF - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (W_DEF - 1));

endpackage

// File: rtl/sat_signed.sv
// rtl/sat_signed.sv - combinational clamp of an IW-bit signed value into the OW-bit signed range
module sat_signed #(
  parameter int IW = 19,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    dout = din[OW-1:0];
    if (din > MAXV) begin
      dout = MAXV[OW-1:0];
    end else if (din < MINV) begin
      dout = MINV[OW-1:0];
    end
  end

endmodule

// File: rtl/mpx_encoder.sv
// rtl/mpx_encoder.sv - 3-stage MPX builder: (L+R)/2 + (L-R)/2*sub38 + pilot19/2^PILOT_SHIFT, saturated
module mpx_encoder
  import mpx_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int B           = B_DEF,
  parameter int PILOT_SHIFT = PILOT_SHIFT_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enableclk,
  input  logic                in_valid,
  input  logic                stereo_en,
  input  logic signed [W-1:0] left,
  input  logic signed [W-1:0] right,
  input  logic signed [B-1:0] sub38,
  input  logic signed [B-1:0] pilot19,
  output logic signed [W-1:0] mpx,
  output logic                mpx_valid
);

  localparam int SW = W + (SUMW - W_DEF);
  localparam int AW = W + (ACCW - W_DEF);
  localparam int PW = W + B + 1;

  logic signed [SW-1:0] sum_q, sum_d, diff_q, diff_d;
  logic signed [B-1:0]  sub_q, sub_d, pil_q, pil_d;
  logic                 v1_q, v1_d;
  logic signed [W-1:0]  sums_q, sums_d, pils_q, pils_d;
  logic signed [SW-1:0] prods_q, prods_d;
  logic                 v2_q, v2_d;
  logic signed [W-1:0]  mpx_q, mpx_d;
  logic                 mpx_valid_q, mpx_valid_d;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic signed [W-1:0]  sat_out;

  assign prod = PW'(diff_q) * PW'(sub_q);
  assign acc  = AW'(sums_q) + AW'(prods_q) + AW'(pils_q);

  sat_signed #(.IW(AW), .OW(W)) u_sat (
    .din  (acc),
    .dout (sat_out)
  );

  // Everything holds unless the sample strobe is present.
  always_comb begin
    sum_d       = sum_q;
    diff_d      = diff_q;
    sub_d       = sub_q;
    pil_d       = pil_q;
    v1_d        = v1_q;
    sums_d      = sums_q;
    prods_d     = prods_q;
    pils_d      = pils_q;
    v2_d        = v2_q;
    mpx_d       = mpx_q;
    mpx_valid_d = mpx_valid_q;
    if (enableclk) begin
      sum_d       = SW'(left) + SW'(right);
      diff_d      = stereo_en ? (SW'(left) - SW'(right)) : '0;
      sub_d       = sub38;
      pil_d       = stereo_en ? pilot19 : '0;
      v1_d        = in_valid;
      sums_d      = W'(sum_q >>> 1);
      prods_d     = SW'(prod >>> B);
      pils_d      = W'(pil_q >>> (B - W + PILOT_SHIFT));
      v2_d        = v1_q;
      mpx_d       = sat_out;
      mpx_valid_d = v2_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q       <= '0;
      diff_q      <= '0;
      sub_q       <= '0;
      pil_q       <= '0;
      v1_q        <= 1'b0;
      sums_q      <= '0;
      prods_q     <= '0;
      pils_q      <= '0;
      v2_q        <= 1'b0;
      mpx_q       <= '0;
      mpx_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      diff_q      <= diff_d;
      sub_q       <= sub_d;
      pil_q       <= pil_d;
      v1_q        <= v1_d;
      sums_q      <= sums_d;
      prods_q     <= prods_d;
      pils_q      <= pils_d;
      v2_q        <= v2_d;
      mpx_q       <= mpx_d;
      mpx_valid_q <= mpx_valid_d;
    end
  end

  assign mpx       = mpx_q;
  assign mpx_valid = mpx_valid_q;

endmodule

// File: tb/tb_mpx_encoder.sv
// tb/tb_mpx_encoder.sv - directed self-checking bench for mpx_encoder
module tb_mpx_encoder;

  logic               clock = 1'b0;
  logic               reset;
  logic               enableclk;
  logic               in_valid;
  logic               stereo_en;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic signed [31:0] sub38;
  logic signed [31:0] pilot19;
  logic signed [15:0] mpx;
  logic               mpx_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  mpx_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .enableclk (enableclk),
    .in_valid  (in_valid),
    .stereo_en (stereo_en),
    .left      (left),
    .right     (right),
    .sub38     (sub38),
    .pilot19   (pilot19),
    .mpx       (mpx),
    .mpx_valid (mpx_valid)
  );

  always #5 clock = ~clock;

  task automatic strobe();
    enableclk = 1'b1;
    @(posedge clock);
    #1;
    enableclk = 1'b0;
  endtask

  task automatic drive(input int l, input int r, input logic [31:0] s, input logic [31:0] p,
                       input logic st, input logic v);
    left      = 16'(l);
    right     = 16'(r);
    sub38     = s;
    pilot19   = p;
    stereo_en = st;
    in_valid  = v;
  endtask

  task automatic check_out(input string name, input int exp_m, input logic exp_v);
    tests_run++;
    if (mpx_valid !== exp_v || int'(mpx) !== exp_m) begin
      tests_failed++;
      $display("FAIL %s: got mpx=%0d valid=%0b, required mpx=%0d valid=%0b",
               name, mpx, mpx_valid, exp_m, exp_v);
    end
  endtask

  // One valid sample, two idle strobes, then the result must be present; one more strobe drops valid.
  task automatic run_one(input string name, input int l, input int r, input logic [31:0] s,
                         input logic [31:0] p, input logic st, input int exp_m);
    drive(l, r, s, p, st, 1'b1);
    strobe();
    in_valid = 1'b0;
    strobe();
    tests_run++;
    if (mpx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_early: got valid=%0b, required valid=0", name, mpx_valid);
    end
    strobe();
    check_out(name, exp_m, 1'b1);
    strobe();
    tests_run++;
    if (mpx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_single: got valid=%0b, required valid=0", name, mpx_valid);
    end
  endtask

  task automatic test_reset();
    check_out("reset_state", 0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_out("reset_release_no_strobe", 0, 1'b0);
  endtask

  task automatic test_mono();
    run_one("mono_1000", 1000, 1000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1000);
    run_one("mono_trunc_pos", 3, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1);
    run_one("mono_trunc_neg", -3, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, -2);
  endtask

  task automatic test_stereo_diff();
    run_one("diff_pos_sub", 1000, -1000, 32'h7FFF_FFFF, 32'h0, 1'b1, 999);
    run_one("diff_neg_sub", 1000, -1000, 32'h8000_0000, 32'h0, 1'b1, -1000);
  endtask

  task automatic test_pilot();
    run_one("pilot_pos", 0, 0, 32'h0, 32'h7FFF_FFFF, 1'b1, 4095);
    run_one("pilot_neg", 0, 0, 32'h0, 32'h8000_0000, 1'b1, -4096);
  endtask

  task automatic test_saturation();
    run_one("sat_pos", 32767, 32767, 32'h0, 32'h7FFF_FFFF, 1'b1, 32767);
    run_one("sat_neg", -32768, -32768, 32'h0, 32'h8000_0000, 1'b1, -32768);
  endtask

  task automatic test_reset_mid();
    drive(1000, 1000, 32'h0, 32'h0, 1'b0, 1'b1);
    strobe();
    strobe();
    strobe();
    check_out("pre_reset_valid", 1000, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_out("reset_async", 0, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe();
      tests_run++;
      if (mpx_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_flush_%0d: got valid=%0b, required valid=0", i, mpx_valid);
      end
    end
  endtask

  // Strobe every 4th clock, 5 back-to-back samples, stereo switched on from the third sample.
  task automatic test_back_to_back();
    int   model [5];
    int   exp_m;
    logic exp_v;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    exp_m = 0;
    exp_v = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 100 * (i + 1) + ((i >= 2) ? 4095 : 0);
    for (int t = 0; t < 8; t++) begin
      if (t < 5) drive(100 * (t + 1), 100 * (t + 1), 32'h0, 32'h7FFF_FFFF, (t >= 2), 1'b1);
      else in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clock);
        #1;
        tests_run++;
        if (mpx_valid !== exp_v || int'(mpx) !== exp_m) begin
          tests_failed++;
          $display("FAIL hold_t%0d_k%0d: got mpx=%0d valid=%0b, required mpx=%0d valid=%0b",
                   t, k, mpx, mpx_valid, exp_m, exp_v);
        end
      end
      strobe();
      if (t >= 2 && t <= 6) begin
        exp_v = 1'b1;
        exp_m = model[t-2];
      end else if (t == 7) begin
        exp_v = 1'b0;
        exp_m = model[4];
      end
      tests_run++;
      if (mpx_valid !== exp_v || int'(mpx) !== exp_m) begin
        tests_failed++;
        $display("FAIL b2b_strobe_%0d: got mpx=%0d valid=%0b, required mpx=%0d valid=%0b",
                 t, mpx, mpx_valid, exp_m, exp_v);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    enableclk = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_mono();
    test_stereo_diff();
    test_pilot();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
